// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter sharing one 12-bit ALU between two requesters, with MAC-burst grant locking.
// Optional statistics counters are enabled with `define ALU_ARB_STATS_EN.
module alu_issue_arbiter #(
  parameter int DATA_W = 12,
  parameter int INST_W = 3,
  parameter int STAT_W = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [1:0]          i_req_valid,
  input  logic [2*INST_W-1:0] i_req_inst,
  input  logic [2*DATA_W-1:0] i_req_data_a,
  input  logic [2*DATA_W-1:0] i_req_data_b,
  input  logic [1:0]          i_req_last,
  output logic [1:0]          o_req_ready,
  output logic                o_alu_valid,
  output logic [INST_W-1:0]   o_alu_inst,
  output logic [DATA_W-1:0]   o_alu_data_a,
  output logic [DATA_W-1:0]   o_alu_data_b,
  input  logic                i_alu_valid,
  input  logic [DATA_W-1:0]   i_alu_data,
  input  logic                i_alu_overflow,
  output logic [1:0]          o_rsp_valid,
  output logic [DATA_W-1:0]   o_rsp_data,
  output logic                o_rsp_overflow,
`ifdef ALU_ARB_STATS_EN
  output logic [STAT_W-1:0]   o_stat_issue0,
  output logic [STAT_W-1:0]   o_stat_issue1,
  output logic [STAT_W-1:0]   o_stat_break,
`endif
  output logic                o_mac_break
);

  localparam int STAGES = 2;
  localparam logic [INST_W-1:0] MAC_OP = INST_W'(3);

  typedef enum logic [1:0] {S_IDLE, S_LOCK, S_GAP} state_t;

  state_t state, state_n;
  logic   owner, owner_n, rr, gnt, brk, accept;
  logic [1:0] rdy, is_mac;

  logic [1:0][INST_W-1:0] inst;
  logic [1:0][DATA_W-1:0] opa, opb;

  // vld_pipe[0]: ALU issue stage, [1]: ALU result stage, [2]: response stage
  logic [STAGES:0] vld_pipe;
  logic [STAGES:0] id_pipe;

  for (genvar r = 0; r < 2; r++) begin : g_unpack
    assign inst[r]   = i_req_inst[r*INST_W +: INST_W];
    assign opa[r]    = i_req_data_a[r*DATA_W +: DATA_W];
    assign opb[r]    = i_req_data_b[r*DATA_W +: DATA_W];
    assign is_mac[r] = (inst[r] == MAC_OP);
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    gnt     = 1'b0;
    rdy     = '0;
    brk     = 1'b0;
    case (state)
      S_IDLE: begin
        gnt = (&i_req_valid) ? rr : i_req_valid[1];
        if (|i_req_valid) begin
          rdy[gnt] = 1'b1;
          if (is_mac[gnt]) begin
            owner_n = gnt;
            state_n = i_req_last[gnt] ? S_GAP : S_LOCK;
          end
        end
      end
      S_LOCK: begin
        gnt = owner;
        if (i_req_valid[owner] && is_mac[owner]) begin
          rdy[owner] = 1'b1;
          if (i_req_last[owner]) state_n = S_GAP;
        end else begin
          // The resulting issue bubble clears the ALU accumulator.
          brk     = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_GAP:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (i_rst) begin
      rdy = '0;
      brk = 1'b0;
    end
  end

  assign o_req_ready = rdy;
  assign accept      = |rdy;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= S_IDLE;
      owner          <= 1'b0;
      rr             <= 1'b0;
      o_alu_valid    <= 1'b0;
      o_alu_inst     <= '0;
      o_alu_data_a   <= '0;
      o_alu_data_b   <= '0;
      vld_pipe       <= '0;
      id_pipe        <= '0;
      o_rsp_data     <= '0;
      o_rsp_overflow <= 1'b0;
      o_mac_break    <= 1'b0;
    end else begin
      state        <= state_n;
      owner        <= owner_n;
      if (accept) rr <= ~gnt;
      o_alu_valid  <= accept;
      o_alu_inst   <= accept ? inst[gnt] : '0;
      o_alu_data_a <= accept ? opa[gnt]  : '0;
      o_alu_data_b <= accept ? opb[gnt]  : '0;
      vld_pipe     <= {vld_pipe[1] & i_alu_valid, vld_pipe[0], accept};
      id_pipe      <= {id_pipe[1], id_pipe[0], gnt};
      o_rsp_data     <= (vld_pipe[1] && i_alu_valid) ? i_alu_data : '0;
      o_rsp_overflow <= vld_pipe[1] && i_alu_valid && i_alu_overflow;
      o_mac_break    <= brk;
    end
  end

  assign o_rsp_valid = vld_pipe[2] ? (id_pipe[2] ? 2'b10 : 2'b01) : 2'b00;

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stat_issue0 <= '0;
      o_stat_issue1 <= '0;
      o_stat_break  <= '0;
    end else begin
      if (rdy[0] && (o_stat_issue0 != '1)) o_stat_issue0 <= o_stat_issue0 + 1'b1;
      if (rdy[1] && (o_stat_issue1 != '1)) o_stat_issue1 <= o_stat_issue1 + 1'b1;
      if (brk    && (o_stat_break  != '1)) o_stat_break  <= o_stat_break + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: behavioural 12-bit ALU (ADD=000, MAC=011 Q5) plus response scoreboard.
module tb_alu_issue_arbiter;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] MAC = 3'b011;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]       req_valid, req_last, rdy, rsp_valid;
  logic [1:0][2:0]  req_inst;
  logic [1:0][11:0] req_a, req_b;
  logic             alu_valid, av, ao, rsp_ovf, mac_break;
  logic [2:0]       alu_inst;
  logic [11:0]      alu_a, alu_b, ad, rsp_data;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]      st_i0, st_i1, st_brk;
`endif

  always #5 clk = ~clk;

  alu_issue_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_inst(req_inst),
    .i_req_data_a(req_a), .i_req_data_b(req_b), .i_req_last(req_last),
    .o_req_ready(rdy),
    .o_alu_valid(alu_valid), .o_alu_inst(alu_inst),
    .o_alu_data_a(alu_a), .o_alu_data_b(alu_b),
    .i_alu_valid(av), .i_alu_data(ad), .i_alu_overflow(ao),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_overflow(rsp_ovf),
`ifdef ALU_ARB_STATS_EN
    .o_stat_issue0(st_i0), .o_stat_issue1(st_i1), .o_stat_break(st_brk),
`endif
    .o_mac_break(mac_break)
  );

  // Behavioural ALU: accumulator survives only across consecutive MAC issue cycles.
  logic signed [11:0] sa, sb;
  logic signed [23:0] prod;
  logic [11:0] pr, acc, res;
  logic [12:0] sum, msum;
  logic        ovf;
  assign sa = alu_a;
  assign sb = alu_b;
  always_comb begin
    prod = 24'(sa) * 24'(sb);
    pr   = prod[16:5];
    sum  = {alu_a[11], alu_a} + {alu_b[11], alu_b};
    msum = {acc[11], acc} + {pr[11], pr};
    res  = '0;
    ovf  = 1'b0;
    if (alu_valid) begin
      case (alu_inst)
        ADD: begin res = sum[11:0];  ovf = sum[12] ^ sum[11];   end
        MAC: begin res = msum[11:0]; ovf = msum[12] ^ msum[11]; end
        default: ;
      endcase
    end
  end
  always @(posedge clk) begin
    if (rst) begin
      av <= 1'b0; ad <= '0; ao <= 1'b0; acc <= '0;
    end else begin
      av  <= alu_valid;
      ad  <= res;
      ao  <= ovf;
      acc <= (alu_valid && alu_inst == MAC) ? res : '0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [1:0] v; logic [11:0] d; logic o; int due; } exp_t;
  exp_t sbq[$];
  int n_vec = 0, n_err = 0, brk_seen = 0, acc_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int r, input logic v, input logic [2:0] inst,
                         input logic [11:0] a, input logic [11:0] b, input logic last);
    req_valid[r] = v; req_inst[r] = inst; req_a[r] = a; req_b[r] = b; req_last[r] = last;
  endtask

  task automatic push(input int r, input logic [11:0] d, input logic o);
    exp_t e;
    e.v = (r == 0) ? 2'b01 : 2'b10;
    e.d = d; e.o = o; e.due = acc_cyc + 3;
    sbq.push_back(e);
  endtask

  // One clock: sample accepts and responses at negedge, then return just after posedge.
  task automatic tick(output logic [1:0] acc_b);
    exp_t e;
    @(negedge clk);
    acc_cyc = cyc;
    acc_b = req_valid & rdy;
    if (mac_break) brk_seen++;
    if (rsp_valid != 2'b00) begin
      if (sbq.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 0);
      else begin
        e = sbq.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(e.v));
        chk("rsp_data",  32'(rsp_data),  32'(e.d));
        chk("rsp_ovf",   32'(rsp_ovf),   32'(e.o));
        chk("rsp_cycle", cyc, e.due);
      end
    end
    while (sbq.size() > 0 && cyc > sbq[0].due) begin
      chk("rsp_missing", 0, 1);
      void'(sbq.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    logic [1:0] a;
    req_valid = 2'b00;
    repeat (n) tick(a);
  endtask

  task automatic do_reset();
    logic [1:0] a;
    rst = 1'b1;
    req_valid = 2'b00;
    sbq.delete();
    tick(a);
    tick(a);
    rst = 1'b0;
  endtask

  typedef struct { int r; logic [2:0] inst; logic [11:0] a, b; logic last; logic [11:0] d; logic o; } vec_t;
  vec_t tbl[8];

  initial begin
    logic [1:0] a;
    bit got;
    int b0;
    tbl[0] = '{0, ADD, 12'd100,  12'd200,  1'b0, 12'h12C, 1'b0};
    tbl[1] = '{1, ADD, 12'h7FF,  12'h7FF,  1'b0, 12'hFFE, 1'b1};
    tbl[2] = '{0, ADD, 12'h800,  12'hFFF,  1'b0, 12'h7FF, 1'b1};
    tbl[3] = '{1, ADD, 12'd0,    12'd0,    1'b0, 12'h000, 1'b0};
    tbl[4] = '{0, ADD, 12'd1000, 12'hC18,  1'b0, 12'h000, 1'b0};
    tbl[5] = '{1, ADD, 12'hFFF,  12'hFFF,  1'b0, 12'hFFE, 1'b0};
    tbl[6] = '{0, MAC, 12'd64,   12'd32,   1'b1, 12'h040, 1'b0};
    tbl[7] = '{1, ADD, 12'd1,    12'd1,    1'b0, 12'h002, 1'b0};

    rst = 1'b1; req_valid = '0; req_inst = '0; req_a = '0; req_b = '0; req_last = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset in the middle of traffic drops in-flight results
    set_req(0, 1, ADD, 12'd1, 12'd1, 0);
    tick(a); chk("t1_acc0", 32'(a), 1); if (a[0]) push(0, 12'd2, 0);
    set_req(0, 0, ADD, 0, 0, 0); set_req(1, 1, ADD, 12'd2, 12'd2, 0);
    tick(a); chk("t1_acc1", 32'(a), 2); if (a[1]) push(1, 12'd4, 0);
    set_req(0, 1, ADD, 12'd3, 12'd3, 0);
    rst = 1'b1; sbq.delete();
    #1 chk("t1_rdy_in_rst", 32'(rdy), 0);
    tick(a);
    chk("t1_rdy", 32'(rdy), 0);
    chk("t1_alu", {alu_valid, alu_inst, alu_a, alu_b}, 0);
    chk("t1_rsp", {rsp_valid, rsp_data, rsp_ovf, mac_break}, 0);
    tick(a);
    rst = 1'b0;
    drain(6);
    chk("t1_sb_empty", sbq.size(), 0);

    // Table of single-requester ops issued back-to-back
    foreach (tbl[i]) begin
      set_req(tbl[i].r, 1, tbl[i].inst, tbl[i].a, tbl[i].b, tbl[i].last);
      got = 0;
      for (int k = 0; k < 4 && !got; k++) begin
        tick(a);
        if (a[tbl[i].r]) begin got = 1; push(tbl[i].r, tbl[i].d, tbl[i].o); end
      end
      chk("tbl_accept", 32'(got), 1);
      req_valid = 2'b00;
    end
    drain(6);
    chk("tbl_sb_empty", sbq.size(), 0);

    // MAC burst locks the grant; pending r1 waits past the GAP cycle
    do_reset();
    set_req(0, 1, MAC, 12'd32, 12'd32, 0);
    set_req(1, 1, ADD, 12'd7, 12'd8, 0);
    tick(a); chk("t3_c0", 32'(a), 1); if (a[0]) push(0, 12'd32, 0);
    tick(a); chk("t3_c1", 32'(a), 1); if (a[0]) push(0, 12'd64, 0);
    req_last[0] = 1'b1;
    tick(a); chk("t3_c2", 32'(a), 1); if (a[0]) push(0, 12'd96, 0);
    req_valid[0] = 1'b0;
    tick(a); chk("t3_gap", 32'(a), 0);
    tick(a); chk("t3_c4", 32'(a), 2); if (a[1]) push(1, 12'd15, 0);
    drain(6);
    chk("t3_sb_empty", sbq.size(), 0);

    // Simultaneous ADDs, then MAC break, then overflow; stats cover all three
    do_reset();
    set_req(0, 1, ADD, 12'd5, 12'd3, 0);
    set_req(1, 1, ADD, 12'hFFE, 12'd1, 0);
    tick(a); chk("t2_c0", 32'(a), 1); if (a[0]) push(0, 12'd8, 0);
    req_valid[0] = 1'b0;
    tick(a); chk("t2_c1", 32'(a), 2); if (a[1]) push(1, 12'hFFF, 0);
    drain(5);

    b0 = brk_seen;
    set_req(0, 1, MAC, 12'd32, 12'd32, 0);
    tick(a); chk("t4_b1", 32'(a), 1); if (a[0]) push(0, 12'd32, 0);
    req_valid[0] = 1'b0;
    tick(a); chk("t4_drop", 32'(a), 0);
    set_req(0, 1, MAC, 12'd32, 12'd32, 1);
    tick(a); chk("t4_b2", 32'(a), 1); if (a[0]) push(0, 12'd32, 0);
    drain(5);
    chk("t4_break", brk_seen - b0, 1);

    set_req(1, 1, ADD, 12'h7FF, 12'd1, 0);
    tick(a); chk("t5_acc", 32'(a), 2); if (a[1]) push(1, 12'h800, 1);
    drain(6);
    chk("t5_sb_empty", sbq.size(), 0);
`ifdef ALU_ARB_STATS_EN
    chk("stat_issue0", 32'(st_i0), 3);
    chk("stat_issue1", 32'(st_i1), 2);
    chk("stat_break",  32'(st_brk), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
